// File: rtl/ad7643_pkg.sv
// Shared types and widths for the AD7643 serial-slave readout engine.
package ad7643_pkg;
  localparam int DATA_W   = 18;
  localparam int SH_CNT_W = $clog2(DATA_W);
  localparam int TMR_W    = 16;

  typedef enum logic [2:0] {IDLE, CNV, WBH, WBL, SHIFT, DONE} state_e;
endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/ad7643_serial_reader.sv
// Convert-and-read engine for one AD7643 in serial-slave mode; samples leave on a valid/ready port.
module ad7643_serial_reader
  import ad7643_pkg::*;
#(
  parameter int SCLK_HALF = 2,
  parameter int CNV_LOW   = 4,
  parameter int BUSY_TMO  = 255
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              EN,
  input  logic              CLR,
  output logic              ADCS,
  output logic              ADCNVST,
  output logic              ADSCLK,
  input  logic              ADSDOUT,
  input  logic              ADBUSY,
  output logic [DATA_W-1:0] SAMPLE,
  output logic              SVALID,
  input  logic              SREADY,
  output logic              OVF,
  output logic              TMO,
  output logic [15:0]       NSAMP
);
  state_e                state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [SH_CNT_W-1:0]   bit_q, bit_d;
  logic                  sclk_q, sclk_d;
  logic [DATA_W-1:0]     sh_q, sh_d;
  logic [DATA_W-1:0]     sample_q, sample_d;
  logic                  svalid_q, svalid_d;
  logic                  ovf_q, ovf_d;
  logic                  tmo_q, tmo_d;
  logic [15:0]           nsamp_q, nsamp_d;
  logic                  adcs_q, adcnvst_q;
  logic                  busy_s;

  sync2 u_busy_sync (.clk_i(CLK), .rst_ni(RSTN), .d_i(ADBUSY), .q_o(busy_s));

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q + TMR_W'(1);
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    sh_d     = sh_q;
    sample_d = sample_q;
    svalid_d = svalid_q && !SREADY;
    ovf_d    = ovf_q;
    tmo_d    = tmo_q;
    nsamp_d  = nsamp_q;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (EN) state_d = CNV;
      end
      CNV: if (tmr_q == TMR_W'(CNV_LOW - 1)) begin
        state_d = WBH;
        tmr_d   = '0;
      end
      WBH: if (busy_s) begin
        state_d = WBL;
        tmr_d   = '0;
      end else if (tmr_q == TMR_W'(BUSY_TMO - 1)) begin
        tmo_d   = 1'b1;
        state_d = IDLE;
      end
      WBL: if (!busy_s) begin
        state_d = SHIFT;
        tmr_d   = '0;
        bit_d   = '0;
        sclk_d  = 1'b0;
      end else if (tmr_q == TMR_W'(BUSY_TMO - 1)) begin
        tmo_d   = 1'b1;
        state_d = IDLE;
      end
      SHIFT: if (tmr_q == TMR_W'(SCLK_HALF - 1)) begin
        // End of a half period: toggle SCLK; capture data just before each fall.
        tmr_d  = '0;
        sclk_d = !sclk_q;
        if (sclk_q) begin
          sh_d = {sh_q[DATA_W-2:0], ADSDOUT};
          if (bit_q == SH_CNT_W'(DATA_W - 1)) state_d = DONE;
          else                                 bit_d   = bit_q + SH_CNT_W'(1);
        end
      end
      DONE: begin
        tmr_d   = '0;
        state_d = EN ? CNV : IDLE;
        if (!svalid_q || SREADY) begin
          sample_d = sh_q;
          svalid_d = 1'b1;
          nsamp_d  = nsamp_q + 16'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (CLR) begin
      ovf_d   = 1'b0;
      tmo_d   = 1'b0;
      nsamp_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      sh_q      <= '0;
      sample_q  <= '0;
      svalid_q  <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
      nsamp_q   <= '0;
      adcs_q    <= 1'b1;
      adcnvst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      sh_q      <= sh_d;
      sample_q  <= sample_d;
      svalid_q  <= svalid_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
      nsamp_q   <= nsamp_d;
      // Pin strobes are decoded from next state so they leave flops aligned with state_q.
      adcs_q    <= (state_d == IDLE);
      adcnvst_q <= (state_d != CNV);
    end
  end

  assign ADCS    = adcs_q;
  assign ADCNVST = adcnvst_q;
  assign ADSCLK  = sclk_q;
  assign SAMPLE  = sample_q;
  assign SVALID  = svalid_q;
  assign OVF     = ovf_q;
  assign TMO     = tmo_q;
  assign NSAMP   = nsamp_q;
endmodule

// File: tb/tb_ad7643_serial_reader.sv
// Directed bench with a behavioural AD7643 and a sample scoreboard.
module tb_ad7643_serial_reader;
  import ad7643_pkg::*;

  localparam int BUSY_TMO = 255;

  logic        CLK = 1'b0;
  logic        RSTN, EN, CLR, SREADY;
  logic        ADCS, ADCNVST, ADSCLK;
  logic        ADSDOUT = 1'b0;
  logic        ADBUSY  = 1'b0;
  logic [17:0] SAMPLE;
  logic        SVALID, OVF, TMO;
  logic [15:0] NSAMP;

  ad7643_serial_reader #(.SCLK_HALF(2), .CNV_LOW(4), .BUSY_TMO(BUSY_TMO)) dut (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .CLR(CLR),
    .ADCS(ADCS), .ADCNVST(ADCNVST), .ADSCLK(ADSCLK), .ADSDOUT(ADSDOUT), .ADBUSY(ADBUSY),
    .SAMPLE(SAMPLE), .SVALID(SVALID), .SREADY(SREADY),
    .OVF(OVF), .TMO(TMO), .NSAMP(NSAMP)
  );

  always #4 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [17:0] adc_q[$];   // words the ADC model will convert
  logic [17:0] exp_q[$];   // words expected to be accepted
  logic [17:0] acc_q[$];   // words observed crossing the handshake
  int vec = 0, miscmp = 0;
  bit no_busy = 1'b0;

  // ADC model: BUSY pulse after CNV falls, MSB presented at BUSY fall, shift on SCLK fall.
  logic        m_pcnv = 1'b1, m_psclk = 1'b0;
  int          m_cnt = 0;
  logic [17:0] m_word = '0, m_sreg = '0, tmpw;
  always @(posedge CLK) begin
    m_pcnv  <= ADCNVST;
    m_psclk <= ADSCLK;
    if (m_pcnv && !ADCNVST && !no_busy) m_cnt <= 1;
    else if (m_cnt != 0)                m_cnt <= m_cnt + 1;
    if (m_cnt == 3) begin
      tmpw = (adc_q.size() != 0) ? adc_q.pop_front() : 18'h0;
      m_word <= tmpw;
      ADBUSY <= 1'b1;
    end
    if (m_cnt == 23) begin
      ADBUSY  <= 1'b0;
      m_sreg  <= m_word;
      ADSDOUT <= m_word[17];
      m_cnt   <= 0;
    end else if (m_psclk && !ADSCLK) begin
      m_sreg  <= m_sreg << 1;
      ADSDOUT <= m_sreg[16];
    end
  end

  int cnv_low = 0, sclk_rise = 0, sv_cyc = 0;
  logic sclk_prev = 1'b0;
  always @(negedge CLK) begin
    if (SVALID && SREADY) acc_q.push_back(SAMPLE);
    if (!ADCNVST) cnv_low++;
    if (ADSCLK && !sclk_prev) sclk_rise++;
    sclk_prev = ADSCLK;
    if (SVALID) sv_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic pulse_en();
    EN = 1'b1; nxt(1); EN = 1'b0;
  endtask

  task automatic pulse_clr();
    CLR = 1'b1; nxt(1); CLR = 1'b0;
  endtask

  task automatic push(input logic [17:0] w, input bit expect_it);
    adc_q.push_back(w);
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (acc_q.size() < n && k < budget) begin nxt(1); k++; end
    chk("acc_count", acc_q.size(), n);
    while (acc_q.size() > 0 && exp_q.size() > 0) chk("sample", acc_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic chk_reset();
    chk("rst_adcs", ADCS, 1);       chk("rst_adcnvst", ADCNVST, 1);
    chk("rst_adsclk", ADSCLK, 0);   chk("rst_sample", SAMPLE, 0);
    chk("rst_svalid", SVALID, 0);   chk("rst_ovf", OVF, 0);
    chk("rst_tmo", TMO, 0);         chk("rst_nsamp", NSAMP, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, b_cnv, b_sclk, b_sv;
    int unsigned t0;
    RSTN = 1'b0; EN = 1'b0; CLR = 1'b0; SREADY = 1'b0;
    nxt(3);
    chk_reset();
    RSTN = 1'b1;
    nxt(2);

    // Single conversion, EN pulsed
    SREADY = 1'b1;
    b_cnv = cnv_low; b_sclk = sclk_rise; b_sv = sv_cyc;
    push(18'h2A5A5, 1);
    pulse_en();
    wait_acc(1, 1000);
    nxt(5);
    chk("single_cnv_width", cnv_low - b_cnv, 4);
    chk("single_sclk_rises", sclk_rise - b_sclk, 18);
    chk("single_svalid_cyc", sv_cyc - b_sv, 1);
    chk("single_nsamp", NSAMP, 1);
    chk("single_sample", SAMPLE, 18'h2A5A5);
    chk("single_adcs_idle", ADCS, 1);

    // Continuous run
    pulse_clr();
    chk("clr_nsamp", NSAMP, 0);
    push(18'h00000, 1); push(18'h3FFFF, 1); push(18'h1FFFF, 1);
    EN = 1'b1;
    k = 0;
    while (acc_q.size() < 2 && k < 1000) begin nxt(1); k++; end
    EN = 1'b0;
    wait_acc(3, 1000);
    nxt(3);
    chk("cont_nsamp", NSAMP, 3);
    chk("cont_ovf", OVF, 0);

    // Backpressure: second sample dropped
    pulse_clr();
    SREADY = 1'b0;
    push(18'h12345, 1); push(18'h0ABCD, 0);
    EN = 1'b1;
    k = 0;
    while (!SVALID && k < 1000) begin nxt(1); k++; end
    chk("bp_first_valid", SVALID, 1);
    EN = 1'b0;
    k = 0;
    while (!OVF && k < 1000) begin nxt(1); k++; end
    chk("bp_ovf", OVF, 1);
    nxt(4);
    chk("bp_sample_hold", SAMPLE, 18'h12345);
    chk("bp_nsamp", NSAMP, 1);
    chk("bp_svalid_hold", SVALID, 1);
    SREADY = 1'b1;
    wait_acc(1, 5);
    chk("bp_svalid_clear", SVALID, 0);
    pulse_clr();
    chk("bp_ovf_clr", OVF, 0);

    // Busy timeout
    no_busy = 1'b1;
    pulse_en();
    k = 0;
    while (dut.state_q != WBH && k < 50) begin nxt(1); k++; end
    t0 = cyc;
    k = 0;
    while (!TMO && k < 600) begin nxt(1); k++; end
    chk("tmo_latency", cyc - t0, BUSY_TMO);
    chk("tmo_state_idle", dut.state_q == IDLE, 1);
    nxt(2);
    chk("tmo_adcs", ADCS, 1);
    pulse_clr();
    chk("tmo_clr", TMO, 0);
    no_busy = 1'b0;

    // Reset in the middle of a shift
    b_sclk = sclk_rise;
    push(18'h15555, 0);
    pulse_en();
    k = 0;
    while (sclk_rise - b_sclk < 9 && k < 500) begin nxt(1); k++; end
    chk("mid_sclk_reached", sclk_rise - b_sclk >= 9, 1);
    RSTN = 1'b0;
    #1;
    chk_reset();
    nxt(3);
    chk("mid_svalid_low", SVALID, 0);
    RSTN = 1'b1;
    nxt(2);
    push(18'h0F0F0, 1);
    pulse_en();
    wait_acc(1, 1000);
    chk("mid_nsamp", NSAMP, 1);

    // NSAMP wrap
    force dut.nsamp_q = 16'hFFFF;
    nxt(1);
    release dut.nsamp_q;
    nxt(1);
    chk("wrap_preload", NSAMP, 16'hFFFF);
    push(18'h00001, 1);
    pulse_en();
    wait_acc(1, 1000);
    chk("wrap_nsamp", NSAMP, 0);

    // CLR coincident with a DONE load
    push(18'h3C3C3, 1);
    pulse_en();
    k = 0;
    while (dut.state_q != DONE && k < 1000) begin nxt(1); k++; end
    CLR = 1'b1; nxt(1); CLR = 1'b0;
    wait_acc(1, 10);
    chk("clr_load_nsamp", NSAMP, 0);
    chk("clr_load_ovf", OVF, 0);

    // CLR coincident with a DONE drop
    SREADY = 1'b0;
    push(18'h11111, 1);
    pulse_en();
    k = 0;
    while (!SVALID && k < 1000) begin nxt(1); k++; end
    push(18'h22222, 0);
    pulse_en();
    k = 0;
    while (dut.state_q != DONE && k < 1000) begin nxt(1); k++; end
    CLR = 1'b1; nxt(1); CLR = 1'b0;
    chk("clr_drop_ovf", OVF, 0);
    chk("clr_drop_sample", SAMPLE, 18'h11111);
    chk("clr_drop_nsamp", NSAMP, 0);
    SREADY = 1'b1;
    wait_acc(1, 10);

    nxt(5);
    chk("sb_extra_accepts", acc_q.size(), 0);
    chk("sb_missing", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
